// File: rtl/nlprg8_checker.sv
// nlprg8_checker: lock detector and error counter for an 8-bit nonlinear sequence generator.
// Define NLPRG8_CHECKER_CAPTURE_EN to add first-error capture outputs FAIL_EXP/FAIL_GOT/FAIL_VLD.
module nlprg8_checker #(
  parameter int unsigned LOCK_CNT = 4,
  parameter int unsigned LOSS_CNT = 3
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        DIN_VALID,
  input  logic [7:0]  DIN,
  input  logic        CLR_CNT,
  output logic        LOCKED,
  output logic        ERR_PULSE,
  output logic [15:0] ERR_CNT,
`ifdef NLPRG8_CHECKER_CAPTURE_EN
  output logic [7:0]  FAIL_EXP,
  output logic [7:0]  FAIL_GOT,
  output logic        FAIL_VLD,
`endif
  output logic [7:0]  EXPECT
);

  typedef enum logic [1:0] {ST_HUNT, ST_VERIFY, ST_LOCKED} state_t;

  state_t     state;
  logic [3:0] run;
  logic [7:0] pred;
  logic [3:0] run_inc;
  logic       match;
  logic       err;
  logic [7:0] f_din;
  logic [7:0] f_pred;

  function automatic logic [7:0] next_word(input logic [7:0] s);
    logic [7:0] n;
    n[0]   = ~(s[6] ^ s[7]) ^ s[3];
    n[1]   = s[5] ^ s[6] ^ s[0];
    n[2]   = s[3] ^ s[4] ^ s[1];
    n[3]   = s[5] ^ s[2] ^ (~(s[1] | s[0]) & (&s[7:3]));
    n[7:4] = s[6:3];
    return n;
  endfunction

  assign run_inc = run + 4'd1;
  assign match   = (DIN == pred);
  assign err     = DIN_VALID && (state == ST_LOCKED) && !match;
  assign f_din   = next_word(DIN);
  assign f_pred  = next_word(pred);
  assign EXPECT  = pred;

  // Once locked the predictor free-runs; only HUNT and a VERIFY miss reseed from DIN.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state  <= ST_HUNT;
      run    <= 4'd0;
      pred   <= 8'h00;
      LOCKED <= 1'b0;
    end else if (DIN_VALID) begin
      case (state)
        ST_HUNT: begin
          pred  <= f_din;
          run   <= 4'd0;
          state <= ST_VERIFY;
        end
        ST_VERIFY: begin
          if (match) begin
            pred <= f_pred;
            if (run_inc == 4'(LOCK_CNT)) begin
              run    <= 4'd0;
              state  <= ST_LOCKED;
              LOCKED <= 1'b1;
            end else begin
              run <= run_inc;
            end
          end else begin
            pred <= f_din;
            run  <= 4'd0;
          end
        end
        ST_LOCKED: begin
          pred <= f_pred;
          if (match) begin
            run <= 4'd0;
          end else if (run_inc == 4'(LOSS_CNT)) begin
            run    <= 4'd0;
            state  <= ST_HUNT;
            LOCKED <= 1'b0;
          end else begin
            run <= run_inc;
          end
        end
        default: begin
          state  <= ST_HUNT;
          run    <= 4'd0;
          LOCKED <= 1'b0;
        end
      endcase
    end
  end

  // A clear coinciding with an error restarts the count at one rather than zero.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      ERR_PULSE <= 1'b0;
      ERR_CNT   <= 16'd0;
    end else begin
      ERR_PULSE <= err;
      if (CLR_CNT) begin
        ERR_CNT <= {15'd0, err};
      end else if (err && (ERR_CNT != 16'hFFFF)) begin
        ERR_CNT <= ERR_CNT + 16'd1;
      end
    end
  end

`ifdef NLPRG8_CHECKER_CAPTURE_EN
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      FAIL_EXP <= 8'h00;
      FAIL_GOT <= 8'h00;
      FAIL_VLD <= 1'b0;
    end else if (err && (CLR_CNT || !FAIL_VLD)) begin
      FAIL_EXP <= pred;
      FAIL_GOT <= DIN;
      FAIL_VLD <= 1'b1;
    end else if (CLR_CNT) begin
      FAIL_EXP <= 8'h00;
      FAIL_GOT <= 8'h00;
      FAIL_VLD <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_nlprg8_checker.sv
// Scoreboard bench for nlprg8_checker: a behavioural model queues expected outputs, a monitor compares.
// Checks capture outputs too when NLPRG8_CHECKER_CAPTURE_EN is defined.
module tb_nlprg8_checker;

  localparam int LOCK_CNT = 4;
  localparam int LOSS_CNT = 15;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic        DIN_VALID = 1'b0;
  logic [7:0]  DIN = 8'h00;
  logic        CLR_CNT = 1'b0;
  logic        LOCKED;
  logic        ERR_PULSE;
  logic [15:0] ERR_CNT;
  logic [7:0]  EXPECT;
`ifdef NLPRG8_CHECKER_CAPTURE_EN
  logic [7:0]  FAIL_EXP;
  logic [7:0]  FAIL_GOT;
  logic        FAIL_VLD;
`endif

  nlprg8_checker #(.LOCK_CNT(LOCK_CNT), .LOSS_CNT(LOSS_CNT)) dut (
    .CLK(CLK),
    .RST_N(RST_N),
    .DIN_VALID(DIN_VALID),
    .DIN(DIN),
    .CLR_CNT(CLR_CNT),
    .LOCKED(LOCKED),
    .ERR_PULSE(ERR_PULSE),
    .ERR_CNT(ERR_CNT),
`ifdef NLPRG8_CHECKER_CAPTURE_EN
    .FAIL_EXP(FAIL_EXP),
    .FAIL_GOT(FAIL_GOT),
    .FAIL_VLD(FAIL_VLD),
`endif
    .EXPECT(EXPECT)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic        locked;
    logic        pulse;
    logic [15:0] cnt;
    logic [7:0]  pred;
    logic        cap_vld;
    logic [7:0]  cap_exp;
    logic [7:0]  cap_got;
  } exp_t;

  exp_t sbq[$];
  int   checks = 0;
  int   passes = 0;

  // Reference model state: mode 0 = hunting, 1 = verifying, 2 = locked.
  logic [7:0] ftab[256];
  int         m_mode, m_run, m_cnt;
  logic [7:0] m_pred;
  logic       m_cap_vld;
  logic [7:0] m_cap_exp, m_cap_got;

  // Generator step written as parity masks over the state word.
  function automatic logic [7:0] specF(input logic [7:0] s);
    logic [7:0] n;
    n    = (s << 1) & 8'hF0;
    n[0] = 1'b1 ^ ($countones(s & 8'hC8) % 2 == 1);
    n[1] = ($countones(s & 8'h61) % 2 == 1);
    n[2] = ($countones(s & 8'h1A) % 2 == 1);
    n[3] = ($countones(s & 8'h24) % 2 == 1) ^ ((s & 8'hFB) == 8'hF8);
    return n;
  endfunction

  task automatic modelReset();
    m_mode = 0; m_run = 0; m_cnt = 0; m_pred = 8'h00;
    m_cap_vld = 1'b0; m_cap_exp = 8'h00; m_cap_got = 8'h00;
  endtask

  task automatic modelStep(input logic valid, input logic [7:0] din, input logic clr);
    exp_t       e;
    logic       err;
    logic [7:0] old;
    err = 1'b0;
    old = m_pred;
    if (valid) begin
      if (m_mode == 0) begin
        m_pred = ftab[din]; m_run = 0; m_mode = 1;
      end else if (m_mode == 1) begin
        if (din == m_pred) begin
          m_pred = ftab[m_pred];
          m_run++;
          if (m_run == LOCK_CNT) begin m_run = 0; m_mode = 2; end
        end else begin
          m_pred = ftab[din]; m_run = 0;
        end
      end else begin
        err = (din != m_pred);
        m_pred = ftab[m_pred];
        if (err) begin
          m_run++;
          if (m_run == LOSS_CNT) begin m_run = 0; m_mode = 0; end
        end else begin
          m_run = 0;
        end
      end
    end
    if (clr) begin
      m_cnt = err ? 1 : 0;
      m_cap_vld = 1'b0; m_cap_exp = 8'h00; m_cap_got = 8'h00;
    end else if (err && m_cnt < 65535) begin
      m_cnt++;
    end
    if (err && !m_cap_vld) begin
      m_cap_vld = 1'b1; m_cap_exp = old; m_cap_got = din;
    end
    e.locked = (m_mode == 2);
    e.pulse = err;
    e.cnt = 16'(m_cnt);
    e.pred = m_pred;
    e.cap_vld = m_cap_vld;
    e.cap_exp = m_cap_exp;
    e.cap_got = m_cap_got;
    sbq.push_back(e);
  endtask

  task automatic checkOutput(input string name, input int unsigned act, input int unsigned req);
    checks++;
    if (act == req) passes++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
  endtask

  task automatic applyStimulus(input logic valid, input logic [7:0] din, input logic clr);
    @(negedge CLK);
    DIN_VALID = valid;
    DIN = din;
    CLR_CNT = clr;
    modelStep(valid, din, clr);
  endtask

  task automatic sendGood(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b1, m_pred, 1'b0);
  endtask

  task automatic sendBad(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b1, m_pred ^ 8'(1 << $urandom_range(0, 7)), 1'b0);
  endtask

  task automatic lockUp();
    applyStimulus(1'b1, 8'($urandom), 1'b0);
    sendGood(LOCK_CNT);
  endtask

  task automatic checkZeroNow(input string tag);
    checkOutput({tag, "_locked"}, LOCKED, 0);
    checkOutput({tag, "_pulse"}, ERR_PULSE, 0);
    checkOutput({tag, "_cnt"}, ERR_CNT, 0);
    checkOutput({tag, "_expect"}, EXPECT, 0);
`ifdef NLPRG8_CHECKER_CAPTURE_EN
    checkOutput({tag, "_fail_vld"}, FAIL_VLD, 0);
`endif
  endtask

  // Monitor: the DUT presents a fresh output set after every rising edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge CLK);
      #1;
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        checkOutput("locked", LOCKED, e.locked);
        checkOutput("err_pulse", ERR_PULSE, e.pulse);
        checkOutput("err_cnt", ERR_CNT, e.cnt);
        checkOutput("expect", EXPECT, e.pred);
`ifdef NLPRG8_CHECKER_CAPTURE_EN
        checkOutput("fail_vld", FAIL_VLD, e.cap_vld);
        checkOutput("fail_exp", FAIL_EXP, e.cap_exp);
        checkOutput("fail_got", FAIL_GOT, e.cap_got);
`endif
      end
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int errs;
    int waited;
    for (int i = 0; i < 256; i++) ftab[i] = specF(8'(i));
    modelReset();
    #3;
    checkZeroNow("reset");
    @(negedge CLK);
    RST_N = 1'b1;

    $display("[TB] lock-up stream");
    applyStimulus(1'b1, 8'h00, 1'b0);
    applyStimulus(1'b1, 8'h01, 1'b0);
    applyStimulus(1'b1, 8'h03, 1'b0);
    applyStimulus(1'b1, 8'h07, 1'b0);
    applyStimulus(1'b1, 8'h0F, 1'b0);
    applyStimulus(1'b1, 8'h1A, 1'b0);

    $display("[TB] single corrupted word");
    sendGood(2);
    sendBad(1);
    sendGood(3);

    $display("[TB] gaps with garbage");
    for (int i = 0; i < 5; i++) applyStimulus(1'b0, 8'($urandom), 1'b0);
    sendGood(2);

    $display("[TB] loss of lock and relock");
    sendBad(LOSS_CNT);
    lockUp();
    sendGood(2);

    $display("[TB] randomized traffic");
    for (int i = 0; i < 1500; i++) begin
      logic v;
      logic [7:0] d;
      v = ($urandom_range(0, 3) != 0);
      d = ($urandom_range(0, 9) < 8) ? m_pred : 8'($urandom);
      applyStimulus(v, d, ($urandom_range(0, 49) == 0));
    end

    $display("[TB] reset while locked");
    if (m_mode != 2) lockUp();
    sendBad(1);
    sendGood(1);
    @(negedge CLK);
    DIN_VALID = 1'b1;
    RST_N = 1'b0;
    #1;
    checkZeroNow("midlock_reset");
    modelReset();
    modelStep(1'b0, 8'h00, 1'b0);
    @(negedge CLK);
    RST_N = 1'b1;
    DIN_VALID = 1'b0;

    $display("[TB] saturating error counter");
    lockUp();
    errs = 0;
    while (errs < 65545) begin
      sendBad(LOSS_CNT - 1);
      errs += LOSS_CNT - 1;
      sendGood(1);
    end
    sendBad(1);
    applyStimulus(1'b1, m_pred ^ 8'h80, 1'b1);
    applyStimulus(1'b0, 8'h00, 1'b1);
    sendGood(1);
    applyStimulus(1'b0, 8'h00, 1'b0);

    waited = 0;
    while (sbq.size() > 0 && waited < 10) begin
      @(posedge CLK);
      waited++;
    end
    #2;
    if (sbq.size() != 0) begin
      checks++;
      $display("[TB] FAIL drain: %0d entries left, expected 0", sbq.size());
    end
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/nlprg8_checker.md
NLPRG8_CHECKER -- requirements
Module: nlprg8_checker

Interface
REQ-001 SHALL have parameter LOCK_CNT, default 4: consecutive matching words required to declare lock (range 1-15).
REQ-002 SHALL have parameter LOSS_CNT, default 3: consecutive mismatching words while locked that force loss of lock (range 1-15).
REQ-003 SHALL have ports:
 CLK       input   1   single clock, all state updates on rising edge.
 RST_N     input   1   reset; asynchronous, active-low.
 DIN_VALID input   1   DIN carries a sequence word this cycle.
 DIN       input   8   received generator state word, bit 0 = o0 ... bit 7 = o7.
 CLR_CNT   input   1   synchronous clear of ERR_CNT.
 LOCKED    output  1   checker is synchronised to the stream.
 ERR_PULSE output  1   one-cycle strobe per mismatching word while locked.
 ERR_CNT   output  16  saturating count of mismatching words while locked.
 EXPECT    output  8   predicted value of the next valid word.

Function
REQ-004 SHALL implement next-state function f(s), s[7:0]: n0 = ~(s6^s7)^s3; n1 = s5^s6^s0; n2 = s3^s4^s1; n3 = s5^s2^(~(s1|s0) & s7&s6&s5&s4&s3); n4 = s3; n5 = s4; n6 = s5; n7 = s6.
REQ-005 SHALL hold state machine HUNT, VERIFY, LOCKED, plus 4-bit run counter RUN and 8-bit predictor PRED; EXPECT = PRED.
REQ-006 SHALL ignore DIN entirely on cycles with DIN_VALID=0; no state, counter or PRED change.
REQ-007 HUNT, valid word: PRED <= f(DIN), RUN <= 0, go VERIFY.
REQ-008 VERIFY, valid DIN==PRED: PRED <= f(PRED), RUN <= RUN+1; when RUN+1 == LOCK_CNT go LOCKED with RUN <= 0.
REQ-009 VERIFY, valid DIN!=PRED: PRED <= f(DIN), RUN <= 0, stay VERIFY (reseed); no error counted.
REQ-010 LOCKED, valid word: PRED <= f(PRED) regardless of match (free-running prediction, never reseeded from DIN).
REQ-011 LOCKED, match: RUN <= 0; mismatch: RUN <= RUN+1, ERR_PULSE=1 next cycle, ERR_CNT increments.
REQ-012 LOCKED, mismatch with RUN+1 == LOSS_CNT: go HUNT, RUN <= 0; this word is still counted as an error.
REQ-013 LOCKED output SHALL be 1 exactly when state is LOCKED (registered, asserts the cycle after the LOCK_CNT-th match).
REQ-014 ERR_CNT SHALL saturate at 0xFFFF and never wrap.
REQ-015 CLR_CNT and a counted error in the same cycle SHALL leave ERR_CNT = 1; CLR_CNT alone leaves 0; CLR_CNT does not affect state, PRED or RUN.
REQ-016 All outputs SHALL be registered; ERR_PULSE latency is one cycle after the valid mismatching word.

Reset
REQ-017 RST_N=0 SHALL immediately force state HUNT, RUN=0, PRED=0x00, LOCKED=0, ERR_PULSE=0, ERR_CNT=0, and any capture registers to 0.
REQ-018 Reset asserted mid-lock SHALL discard lock; after release the checker re-hunts from the next valid word.

Configuration
REQ-019 Macro NLPRG8_CHECKER_CAPTURE_EN, when defined, SHALL add outputs FAIL_EXP[7:0], FAIL_GOT[7:0], FAIL_VLD: PRED and DIN of the first counted error after reset or CLR_CNT, held until reset or CLR_CNT (CLR_CNT also clears FAIL_VLD).
REQ-020 Without NLPRG8_CHECKER_CAPTURE_EN those ports and registers SHALL not exist; all other behaviour identical.

Verification
REQ-021 Reset, then valid stream 0x00,0x01,0x03,0x07,0x0F,0x1A -> VERIFY after 0x00, LOCKED=1 the cycle after 0x0F, EXPECT=f(0x1A) after 0x1A, ERR_CNT=0.
REQ-022 Locked stream, corrupt one word (expected 0x1A, send 0x1B) -> ERR_PULSE one cycle, ERR_CNT=1, LOCKED stays 1, next correct word matches.
REQ-023 Locked stream, three consecutive corrupted words -> ERR_CNT=3, LOCKED=0 after third, relock after 1 seed + 4 matching words.
REQ-024 Gaps: DIN_VALID low for 5 cycles mid-stream with garbage DIN -> no errors, no PRED change, lock retained.
REQ-025 Force ERR_CNT to 0xFFFF via continuous errors (LOSS_CNT=15, relock periodically) -> holds 0xFFFF; CLR_CNT with simultaneous error -> 1.
REQ-026 RST_N low mid-lock for 1 cycle -> all outputs 0 immediately; with CAPTURE_EN, FAIL_EXP/FAIL_GOT match first injected error only.
